avs_memory_responder: RTL

AVS_MEMORY_RESPONDER -- requirements
Module: avs_memory_responder

---
 rtl/avs_memory_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/avs_memory_responder.sv
// Avalon-MM slave backed by a word-addressed memory, with programmable wait states,
// range checking against BASE_ADDR, and saturating read/write/error counters.
module avs_memory_responder #(
    parameter int AVS_AVALONSLAVE_DATA_WIDTH    = 32,
    parameter int AVS_AVALONSLAVE_ADDRESS_WIDTH = 32,
    parameter int DEPTH_LOG2                    = 8,
    parameter int WAIT_STATES                   = 2,
    parameter logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                                     CSI_CLOCK_CLK,
    input  logic                                     CSI_CLOCK_RESET,
    input  logic [AVS_AVALONSLAVE_ADDRESS_WIDTH-1:0] AVS_AVALONSLAVE_ADDRESS,
    input  logic                                     AVS_AVALONSLAVE_READ,
    input  logic                                     AVS_AVALONSLAVE_WRITE,
    input  logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_WRITEDATA,
    output logic                                     AVS_AVALONSLAVE_WAITREQUEST,
    output logic [AVS_AVALONSLAVE_DATA_WIDTH-1:0]    AVS_AVALONSLAVE_READDATA,
    output logic [15:0]                              RD_COUNT,
    output logic [15:0]                              WR_COUNT,
    output logic [7:0]                               ERR_COUNT
);

    localparam int DW    = AVS_AVALONSLAVE_DATA_WIDTH;
    localparam int AW    = AVS_AVALONSLAVE_ADDRESS_WIDTH;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0]    WS4      = 4'(WAIT_STATES);
    localparam logic [DW-1:0] OOR_DATA = DW'(32'hDEADBEEF);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [15:0]     rd_cnt_q, rd_cnt_d;
    logic [15:0]     wr_cnt_q, wr_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [DW-1:0]   mem [0:DEPTH-1];

    logic            req;
    logic            eff_rd, eff_wr;
    logic [AW-1:0]   eff_addr, offset, word;
    logic [DW-1:0]   eff_data;
    logic            in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic            commit;
    logic            mem_we;

    assign req = AVS_AVALONSLAVE_READ | AVS_AVALONSLAVE_WRITE;

    // With zero wait states the access commits on the capture edge itself,
    // so the live bus fields are used while idle and the captured ones otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            eff_addr = AVS_AVALONSLAVE_ADDRESS;
            eff_rd   = AVS_AVALONSLAVE_READ;
            eff_wr   = AVS_AVALONSLAVE_WRITE;
            eff_data = AVS_AVALONSLAVE_WRITEDATA;
        end else begin
            eff_addr = addr_q;
            eff_rd   = rd_q;
            eff_wr   = wr_q;
            eff_data = data_q;
        end
    end

    assign offset   = eff_addr - BASE_ADDR;
    assign word     = offset >> 2;
    assign in_range = (eff_addr >= BASE_ADDR) && ((word >> DEPTH_LOG2) == '0);
    assign idx      = word[DEPTH_LOG2-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        commit    = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d = AVS_AVALONSLAVE_ADDRESS;
                    rd_d   = AVS_AVALONSLAVE_READ;
                    wr_d   = AVS_AVALONSLAVE_WRITE;
                    data_d = AVS_AVALONSLAVE_WRITEDATA;
                    cnt_d  = WS4;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            if (eff_rd && eff_wr) begin
                rdata_d = '0;
                if (~&err_cnt_q) err_cnt_d = err_cnt_q + 8'd1;
            end else if (!in_range) begin
                if (eff_rd) rdata_d = OOR_DATA;
                if (~&err_cnt_q) err_cnt_d = err_cnt_q + 8'd1;
            end else if (eff_rd) begin
                rdata_d = mem[idx];
                if (~&rd_cnt_q) rd_cnt_d = rd_cnt_q + 16'd1;
            end else begin
                mem_we = 1'b1;
                if (~&wr_cnt_q) wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (CSI_CLOCK_RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            data_q    <= '0;
            rdata_q   <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            data_q    <= data_d;
            rdata_q   <= rdata_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage survives reset; only the write strobe is gated by it.
    always_ff @(posedge CSI_CLOCK_CLK) begin
        if (mem_we && !CSI_CLOCK_RESET) mem[idx] <= eff_data;
    end

    assign AVS_AVALONSLAVE_WAITREQUEST = req && (CSI_CLOCK_RESET || state_q != ST_RESP);
    assign AVS_AVALONSLAVE_READDATA    = rdata_q;
    assign RD_COUNT                    = rd_cnt_q;
    assign WR_COUNT                    = wr_cnt_q;
    assign ERR_COUNT                   = err_cnt_q;

endmodule
